lr35902_iobus: RTL and testbench
================================

Name: lr35902_iobus

Overview:
- Registered, handshaked I/O-page bus controller for the 0xFF00–0xFFFF high page.
- Decodes the low address byte into one-hot device selects and holds each select for the whole access until the device acknowledges or the access times out.
- Muxes device read data back to the CPU and returns open-bus 0xFF for unmapped addresses.
- Owns the sticky boot-ROM-hide register at 0xFF50 and adds one parameterised extension window for future peripherals.

Parameters:
TIMEOUT_CYC, 7, cycles to wait for dev_ack before forcing completion (1..255)
EXT_BASE, 8'h68, base of extension window; must be aligned to 2**EXT_LOG2
EXT_LOG2, 3, log2 size of extension window (0..4)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
adr  in  8  low address byte of high-page access
wdata  in  8  CPU write data
rd  in  1  read request, sampled in IDLE
wr  in  1  write request, sampled in IDLE; rd&wr together is treated as a write
cs  out  NDEV(9)  one-hot device select, indexed by package constants
dev_ack  in  NDEV  per-device completion; only the selected bit is honoured
dev_rdata  in  8*NDEV  per-device read data, device i at [8i+7:8i]
rdata  out  8  registered read data, valid while ready=1
ready  out  1  one-cycle completion pulse
busy  out  1  high from request acceptance until ready
brom_hide  out  1  sticky boot-ROM hidden flag
timeout_err  out  1  sticky; set when any access times out

Behaviour:
- Reset (synchronous, active-high): state=IDLE; cs=0, rdata=8'hFF, ready=0, busy=0, brom_hide=0, timeout_err=0, timer=0. Reset mid-access aborts it; no ready is emitted.
- Decode priority, first match wins: FF→IE; 0F→IF; 80–FE→HRAM; 50→BROM (internal); 40–4F→PPU; 10–3F→APU; 04–07→TIM; 00→P1; 01–02→ELP; EXT_BASE..EXT_BASE+2**EXT_LOG2-1→EXT; else UNMAPPED.
- The EXT window is checked last, so it cannot shadow fixed devices.
- FSM states: IDLE, ACCESS, DONE.
- IDLE: when rd|wr is high, latch adr, wdata and direction, and set busy=1.
  - Decoded device: next state ACCESS; cs bit asserted from the following cycle.
  - BROM or UNMAPPED: next state DONE; no cs.
- ACCESS: cs held stable; timer counts up each cycle.
  - On dev_ack[sel]=1 with a read: capture dev_rdata slice into rdata; go to DONE.
  - On dev_ack[sel]=1 with a write: rdata unchanged; go to DONE.
  - When timer reaches TIMEOUT_CYC-1 without ack: rdata=8'hFF on reads; set timeout_err; go to DONE.
  - Ack arriving on the timeout cycle counts as ack; timeout_err is not set.
- DONE: cs=0, ready=1 for exactly this cycle, busy cleared on exit; timer=0; return to IDLE.
  - A request present in DONE is ignored; the CPU must re-present it in IDLE.
- Minimum latency with immediate ack: request at cycle 0, cs at cycle 1, ready at cycle 2.
- BROM reads return {7'b1111111, brom_hide}.
- BROM writes with wdata[0]=1 set brom_hide. The flag is cleared only by reset; writes with wdata[0]=0 are ignored.
- UNMAPPED reads return 8'hFF; UNMAPPED writes are dropped.
- Non-selected dev_ack bits are ignored in all states.

Optional Feature:
- Macro: LR35902_IOBUS_TIMEOUT_EN.
- Defined: timeout counter and timeout_err as above.
- Undefined: no counter; ACCESS waits indefinitely for dev_ack; timeout_err is tied to 0; TIMEOUT_CYC is unused.

Decomposition:
- Package lr35902_iobus_pkg holds:
  - device index constants DEV_P1=0, DEV_ELP=1, DEV_TIM=2, DEV_IF=3, DEV_APU=4, DEV_PPU=5, DEV_HRAM=6, DEV_IE=7, DEV_EXT=8, NDEV=9;
  - FSM state enum;
  - OPEN_BUS=8'hFF and ADR_BROM=8'h50.
- One natural sub-module: lr35902_iobus_dec, purely combinational. Inputs are adr plus EXT parameters; outputs are a device index plus is_brom and is_unmapped. The top module holds the FSM, registers and mux.

Test Plan:
- Read 0x45 with PPU acking on cycle 1 and dev_rdata[PPU]=8'h91 → cs[5] high for one cycle; ready on cycle 2; rdata=8'h91; busy high for cycles 1–2.
- Write 0x50 with wdata=8'h01 → no cs; brom_hide=1 after ready. Then write 8'h00 → brom_hide stays 1. Then read 0x50 → rdata=8'hFF. After reset, brom_hide=0 and a read of 0x50 returns 8'hFE.
- Read 0x4C (PPU range), then 0x03, then 0x6A with EXT_BASE=8'h68, EXT_LOG2=3:
  - 0x4C → cs[5];
  - 0x03 → unmapped, ready after 1 cycle, rdata=8'hFF;
  - 0x6A → cs[8].
- Read 0x04 with TIM never acking and the macro defined → cs[2] held 7 cycles; then ready with rdata=8'hFF; timeout_err=1. Without the macro, busy stays high until dev_ack[2] is driven.
- Assert reset while in ACCESS on a HRAM read → next cycle cs=0, busy=0, no ready pulse.
- Read 0xFF and 0x0F with spurious dev_ack on all other bits → only cs[7] / cs[3] respectively; other acks have no effect on completion.

Source files
------------

// File: rtl/lr35902_iobus_pkg.sv
// Shared definitions for the LR35902 high-page I/O bus controller:
// device indices, FSM state encoding and fixed bus constants.
package lr35902_iobus_pkg;

  localparam int NDEV = 9;

  typedef logic [3:0] dev_idx_t;

  localparam dev_idx_t DEV_P1   = 4'd0;
  localparam dev_idx_t DEV_ELP  = 4'd1;
  localparam dev_idx_t DEV_TIM  = 4'd2;
  localparam dev_idx_t DEV_IF   = 4'd3;
  localparam dev_idx_t DEV_APU  = 4'd4;
  localparam dev_idx_t DEV_PPU  = 4'd5;
  localparam dev_idx_t DEV_HRAM = 4'd6;
  localparam dev_idx_t DEV_IE   = 4'd7;
  localparam dev_idx_t DEV_EXT  = 4'd8;

  localparam logic [7:0] OPEN_BUS = 8'hFF;
  localparam logic [7:0] ADR_BROM = 8'h50;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/lr35902_iobus_dec.sv
// Combinational high-page address decoder. Fixed devices are matched in
// priority order; the extension window is tested last so it can never
// shadow a fixed device.
module lr35902_iobus_dec
  import lr35902_iobus_pkg::*;
#(
  parameter logic [7:0]  EXT_BASE = 8'h68,
  parameter int unsigned EXT_LOG2 = 3
) (
  input  logic [7:0] adr,
  output dev_idx_t   dev_idx,
  output logic       is_brom,
  output logic       is_unmapped
);

  localparam logic [7:0] EXT_MASK = 8'(8'hFF << EXT_LOG2);

  // Priority decode, first match wins.
  always_comb begin
    dev_idx     = DEV_P1;
    is_brom     = 1'b0;
    is_unmapped = 1'b0;
    if (adr == 8'hFF)                                  dev_idx = DEV_IE;
    else if (adr == 8'h0F)                             dev_idx = DEV_IF;
    else if (adr[7])                                   dev_idx = DEV_HRAM;
    else if (adr == ADR_BROM)                          is_brom = 1'b1;
    else if (adr[7:4] == 4'h4)                         dev_idx = DEV_PPU;
    else if (adr >= 8'h10 && adr <= 8'h3F)             dev_idx = DEV_APU;
    else if (adr[7:2] == 6'b000001)                    dev_idx = DEV_TIM;
    else if (adr == 8'h00)                             dev_idx = DEV_P1;
    else if (adr == 8'h01 || adr == 8'h02)             dev_idx = DEV_ELP;
    else if ((adr & EXT_MASK) == (EXT_BASE & EXT_MASK)) dev_idx = DEV_EXT;
    else                                               is_unmapped = 1'b1;
  end

endmodule

// File: rtl/lr35902_iobus.sv
// LR35902 high-page I/O bus controller. Accepts one CPU access at a time,
// drives a one-hot device select until ack (or timeout), returns read data
// with a single-cycle ready pulse, and owns the sticky boot-ROM hide flag.
// Build option: LR35902_IOBUS_TIMEOUT_EN enables the ACCESS timeout counter
// and timeout_err; without it ACCESS waits for dev_ack indefinitely.
module lr35902_iobus
  import lr35902_iobus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 7,
  parameter logic [7:0]  EXT_BASE    = 8'h68,
  parameter int unsigned EXT_LOG2    = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        adr,
  input  logic [7:0]        wdata,
  input  logic              rd,
  input  logic              wr,
  output logic [NDEV-1:0]   cs,
  input  logic [NDEV-1:0]   dev_ack,
  input  logic [8*NDEV-1:0] dev_rdata,
  output logic [7:0]        rdata,
  output logic              ready,
  output logic              busy,
  output logic              brom_hide,
  output logic              timeout_err
);

  localparam logic [7:0] EXT_MASK = 8'(8'hFF << EXT_LOG2);

  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255 || EXT_LOG2 > 4 ||
      (EXT_BASE & ~EXT_MASK) != 8'h00) begin : g_bad_cfg
    $error("lr35902_iobus: illegal TIMEOUT_CYC / EXT_BASE / EXT_LOG2");
  end

  state_t   state;
  dev_idx_t sel_q;
  logic     wr_q;

  dev_idx_t dec_idx;
  logic     dec_brom;
  logic     dec_unmapped;
  logic     ack_sel;
  logic     timeout_hit;
  logic [7:0] rd_slice;

  // Only bit 0 of wdata has a meaning inside this block (boot-ROM hide).
  logic unused_wdata;
  assign unused_wdata = ^wdata[7:1];

  lr35902_iobus_dec #(
    .EXT_BASE (EXT_BASE),
    .EXT_LOG2 (EXT_LOG2)
  ) u_dec (
    .adr         (adr),
    .dev_idx     (dec_idx),
    .is_brom     (dec_brom),
    .is_unmapped (dec_unmapped)
  );

  assign ack_sel = dev_ack[sel_q];

  // Read-data mux from the latched device index.
  always_comb begin
    rd_slice = OPEN_BUS;
    for (int i = 0; i < NDEV; i++) begin
      if (sel_q == dev_idx_t'(i)) rd_slice = dev_rdata[8*i +: 8];
    end
  end

`ifdef LR35902_IOBUS_TIMEOUT_EN
  logic [7:0] timer;

  assign timeout_hit = (timer == 8'(TIMEOUT_CYC - 1));

  // Cycle counter for the current ACCESS; zero outside ACCESS.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer <= 8'd0;
    end else if (state == ST_ACCESS && !ack_sel && !timeout_hit) begin
      timer <= timer + 8'd1;
    end else begin
      timer <= 8'd0;
    end
  end

  // Sticky flag: an access ran out of time without an ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      timeout_err <= 1'b0;
    end else if (state == ST_ACCESS && timeout_hit && !ack_sel) begin
      timeout_err <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Access sequencer with registered bus outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      sel_q     <= DEV_P1;
      wr_q      <= 1'b0;
      cs        <= '0;
      rdata     <= OPEN_BUS;
      ready     <= 1'b0;
      busy      <= 1'b0;
      brom_hide <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          ready <= 1'b0;
          if (rd || wr) begin
            busy  <= 1'b1;
            wr_q  <= wr;
            sel_q <= dec_idx;
            if (dec_brom) begin
              state <= ST_DONE;
              ready <= 1'b1;
              if (wr) begin
                if (wdata[0]) brom_hide <= 1'b1;
              end else begin
                rdata <= {7'b1111111, brom_hide};
              end
            end else if (dec_unmapped) begin
              state <= ST_DONE;
              ready <= 1'b1;
              if (!wr) rdata <= OPEN_BUS;
            end else begin
              state <= ST_ACCESS;
              cs    <= NDEV'(1) << dec_idx;
            end
          end
        end
        ST_ACCESS: begin
          if (ack_sel) begin
            if (!wr_q) rdata <= rd_slice;
            cs    <= '0;
            ready <= 1'b1;
            state <= ST_DONE;
          end else if (timeout_hit) begin
            if (!wr_q) rdata <= OPEN_BUS;
            cs    <= '0;
            ready <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          ready <= 1'b0;
          busy  <= 1'b0;
          cs    <= '0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          cs    <= '0;
          ready <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lr35902_iobus.sv
// Self-checking bench for lr35902_iobus: vector table of single accesses,
// a read-data scoreboard checked on every ready pulse, and hand-written
// sequences for timeout / infinite wait and reset during an access.
module tb_lr35902_iobus;
  import lr35902_iobus_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic [7:0]        adr;
  logic [7:0]        wdata;
  logic              rd;
  logic              wr;
  logic [NDEV-1:0]   cs;
  logic [NDEV-1:0]   dev_ack;
  logic [8*NDEV-1:0] dev_rdata;
  logic [7:0]        rdata;
  logic              ready;
  logic              busy;
  logic              brom_hide;
  logic              timeout_err;

  int n_err = 0;
  int n_chk = 0;
  logic [7:0] exp_q[$];
  logic [7:0] model_rdata;

  lr35902_iobus dut (
    .clk         (clk),
    .reset       (reset),
    .adr         (adr),
    .wdata       (wdata),
    .rd          (rd),
    .wr          (wr),
    .cs          (cs),
    .dev_ack     (dev_ack),
    .dev_rdata   (dev_rdata),
    .rdata       (rdata),
    .ready       (ready),
    .busy        (busy),
    .brom_hide   (brom_hide),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard: every ready pulse must match the oldest expected read data.
  always @(negedge clk) begin
    if (!reset && ready) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected_ready: got rdata %0h with no expected entry", rdata);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (rdata !== e) begin
          n_err++;
          $display("FAIL sb_rdata: got %0h expected %0h", rdata, e);
        end
      end
    end
  end

  typedef struct {
    bit         rd;
    bit         wr;
    logic [7:0] adr;
    logic [7:0] wdata;
    int         ack_dly;
    logic [7:0] ack_data;
    logic [8:0] spur;
    logic [8:0] exp_cs;
    logic [7:0] exp_rdata;
    int         exp_lat;
    bit         exp_brom;
    bit         exp_terr;
  } vec_t;

  task automatic fill_rdata(input logic [8:0] sel_bit, input logic [7:0] d);
    for (int i = 0; i < NDEV; i++) begin
      dev_rdata[8*i +: 8] = 8'hA0 + 8'(i);
      if (sel_bit[i]) dev_rdata[8*i +: 8] = d;
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int cyc;
    int cs_bad;
    bit got;
    logic [7:0] e;
    string nm;
    nm = $sformatf("v%0d_%0h", idx, v.adr);
    fill_rdata(v.exp_cs, v.ack_data);
    dev_ack = v.spur;
    adr     = v.adr;
    wdata   = v.wdata;
    rd      = v.rd;
    wr      = v.wr;
    e = v.wr ? model_rdata : v.exp_rdata;
    model_rdata = e;
    exp_q.push_back(e);
    tick();
    rd = 1'b0;
    wr = 1'b0;
    cyc = 1;
    cs_bad = 0;
    got = 1'b0;
    while (cyc <= 40) begin
      if (ready) begin
        got = 1'b1;
        break;
      end
      if (cs !== v.exp_cs) cs_bad++;
      dev_ack = v.spur | ((v.ack_dly >= 0 && cyc == 1 + v.ack_dly) ? v.exp_cs : 9'h000);
      tick();
      cyc++;
    end
    chk({nm, "_latency"}, got ? cyc : 99, v.exp_lat);
    chk({nm, "_cs_hold"}, cs_bad, 0);
    chk({nm, "_cs_done"}, cs, 9'h000);
    chk({nm, "_busy_done"}, busy, 1'b1);
    chk({nm, "_brom"}, brom_hide, v.exp_brom);
    chk({nm, "_terr"}, timeout_err, v.exp_terr);
    dev_ack = '0;
    tick();
    chk({nm, "_ready_1cyc"}, ready, 1'b0);
    chk({nm, "_busy_idle"}, busy, 1'b0);
  endtask

  vec_t vecs[24];

  initial begin
    int cyc;
    int good;
    bit got;

    vecs[0]  = '{1, 0, 8'h45, 8'h00,  0, 8'h91, 9'h000, 9'h020, 8'h91, 2, 0, 0};
    vecs[1]  = '{0, 1, 8'h50, 8'h01, -1, 8'h00, 9'h000, 9'h000, 8'h00, 1, 1, 0};
    vecs[2]  = '{0, 1, 8'h50, 8'h00, -1, 8'h00, 9'h000, 9'h000, 8'h00, 1, 1, 0};
    vecs[3]  = '{1, 0, 8'h50, 8'h00, -1, 8'h00, 9'h000, 9'h000, 8'hFF, 1, 1, 0};
    vecs[4]  = '{1, 0, 8'h4C, 8'h00,  0, 8'h3C, 9'h000, 9'h020, 8'h3C, 2, 1, 0};
    vecs[5]  = '{1, 0, 8'h03, 8'h00, -1, 8'h00, 9'h000, 9'h000, 8'hFF, 1, 1, 0};
    vecs[6]  = '{1, 0, 8'h6A, 8'h00,  1, 8'h5A, 9'h000, 9'h100, 8'h5A, 3, 1, 0};
    vecs[7]  = '{1, 0, 8'hFF, 8'h00,  2, 8'h77, 9'h17F, 9'h080, 8'h77, 4, 1, 0};
    vecs[8]  = '{1, 0, 8'h0F, 8'h00,  0, 8'h21, 9'h1F7, 9'h008, 8'h21, 2, 1, 0};
    vecs[9]  = '{0, 1, 8'h10, 8'h33,  0, 8'h99, 9'h000, 9'h010, 8'h00, 2, 1, 0};
    vecs[10] = '{1, 0, 8'h00, 8'h00,  0, 8'hC1, 9'h000, 9'h001, 8'hC1, 2, 1, 0};
    vecs[11] = '{1, 0, 8'h02, 8'h00,  1, 8'hE2, 9'h000, 9'h002, 8'hE2, 3, 1, 0};
    vecs[12] = '{1, 0, 8'h06, 8'h00,  0, 8'h66, 9'h000, 9'h004, 8'h66, 2, 1, 0};
    vecs[13] = '{1, 0, 8'h80, 8'h00,  0, 8'h18, 9'h000, 9'h040, 8'h18, 2, 1, 0};
    vecs[14] = '{1, 0, 8'hFE, 8'h00,  0, 8'hEF, 9'h000, 9'h040, 8'hEF, 2, 1, 0};
    vecs[15] = '{1, 0, 8'h6F, 8'h00,  0, 8'h6F, 9'h000, 9'h100, 8'h6F, 2, 1, 0};
    vecs[16] = '{1, 0, 8'h67, 8'h00, -1, 8'h00, 9'h000, 9'h000, 8'hFF, 1, 1, 0};
    vecs[17] = '{1, 0, 8'h3F, 8'h00,  0, 8'h3F, 9'h000, 9'h010, 8'h3F, 2, 1, 0};
    vecs[18] = '{1, 0, 8'h70, 8'h00, -1, 8'h00, 9'h000, 9'h000, 8'hFF, 1, 1, 0};
    vecs[19] = '{1, 0, 8'h4F, 8'h00,  0, 8'h4F, 9'h000, 9'h020, 8'h4F, 2, 1, 0};
    vecs[20] = '{1, 0, 8'h51, 8'h00, -1, 8'h00, 9'h000, 9'h000, 8'hFF, 1, 1, 0};
    vecs[21] = '{1, 0, 8'h40, 8'h00,  6, 8'h42, 9'h000, 9'h020, 8'h42, 8, 1, 0};
    vecs[22] = '{1, 0, 8'h08, 8'h00, -1, 8'h00, 9'h000, 9'h000, 8'hFF, 1, 1, 0};
    vecs[23] = '{1, 0, 8'h01, 8'h00,  0, 8'h11, 9'h000, 9'h002, 8'h11, 2, 1, 0};

    reset = 1'b1;
    adr = 8'h00;
    wdata = 8'h00;
    rd = 1'b0;
    wr = 1'b0;
    dev_ack = '0;
    dev_rdata = '0;
    model_rdata = OPEN_BUS;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    chk("rst_cs", cs, 9'h000);
    chk("rst_rdata", rdata, 8'hFF);
    chk("rst_ready", ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_brom", brom_hide, 1'b0);
    chk("rst_terr", timeout_err, 1'b0);

    for (int i = 0; i < 24; i++) run_vec(vecs[i], i);

    // TIM never acks: bounded wait with timeout, or infinite wait without it.
    fill_rdata(9'h004, 8'h44);
    adr = 8'h04;
    rd  = 1'b1;
`ifdef LR35902_IOBUS_TIMEOUT_EN
    exp_q.push_back(OPEN_BUS);
    model_rdata = OPEN_BUS;
    tick();
    rd = 1'b0;
    cyc = 1;
    good = 0;
    got = 1'b0;
    while (cyc <= 40) begin
      if (ready) begin
        got = 1'b1;
        break;
      end
      if (cs === 9'h004) good++;
      tick();
      cyc++;
    end
    chk("tmo_latency", got ? cyc : 99, 8);
    chk("tmo_cs_cycles", good, 7);
    chk("tmo_terr", timeout_err, 1'b1);
    tick();
    chk("tmo_busy_idle", busy, 1'b0);
    chk("tmo_terr_sticky", timeout_err, 1'b1);
`else
    exp_q.push_back(8'h44);
    model_rdata = 8'h44;
    tick();
    rd = 1'b0;
    good = 0;
    for (int k = 0; k < 20; k++) begin
      if (busy === 1'b1 && cs === 9'h004 && ready === 1'b0) good++;
      tick();
    end
    chk("wait_busy_held", good, 20);
    dev_ack = 9'h004;
    got = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (ready) begin
        got = 1'b1;
        break;
      end
      tick();
      dev_ack = '0;
    end
    dev_ack = '0;
    chk("wait_ack_ready", got, 1'b1);
    chk("wait_terr", timeout_err, 1'b0);
    tick();
    chk("wait_busy_idle", busy, 1'b0);
`endif

    // Reset during an HRAM read aborts it silently.
    fill_rdata(9'h040, 8'h5E);
    adr = 8'h80;
    rd  = 1'b1;
    tick();
    rd = 1'b0;
    tick();
    chk("abort_cs_before", cs, 9'h040);
    reset = 1'b1;
    tick();
    chk("abort_cs", cs, 9'h000);
    chk("abort_busy", busy, 1'b0);
    chk("abort_ready", ready, 1'b0);
    reset = 1'b0;
    good = 0;
    for (int k = 0; k < 3; k++) begin
      if (ready === 1'b0 && busy === 1'b0) good++;
      tick();
    end
    chk("abort_no_ready", good, 3);
    chk("abort_rdata", rdata, 8'hFF);
    chk("abort_brom", brom_hide, 1'b0);
    chk("abort_terr", timeout_err, 1'b0);
    model_rdata = OPEN_BUS;

    run_vec('{1, 0, 8'h50, 8'h00, -1, 8'h00, 9'h000, 9'h000, 8'hFE, 1, 0, 0}, 100);
    // rd and wr together behave as a write.
    run_vec('{1, 1, 8'h50, 8'h01, -1, 8'h00, 9'h000, 9'h000, 8'h00, 1, 1, 0}, 101);
    run_vec('{1, 0, 8'h50, 8'h00, -1, 8'h00, 9'h000, 9'h000, 8'hFF, 1, 1, 0}, 102);

    tick();
    chk("sb_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
